// File: rtl/debug_hex_panel.sv
// debug_hex_panel
//   Seven-segment readout for NUM_SRC debug words, NUM_DIGITS hex digits each.
//   Two debounced buttons are supported:
//     - btn_next advances the displayed source.
//     - btn_freeze toggles a snapshot of all sources.
//   An auto-rotate mode steps through the sources every ROT_CYCLES clocks.
//
//   Optional build macro: DEBUG_PANEL_CHANGE_FLASH_EN
//     When defined, a digit whose value changes in LIVE/AUTO is blanked for
//     FLASH_CYCLES clocks before it shows the new value.
//     When undefined, led is always the plain hex decode.
//
// Ports
//   clk         system clock
//   rst         synchronous reset, active-high
//   src_data    NUM_SRC words; word k at [k*DATA_W +: DATA_W]
//   btn_next    raw button: advance to the next source
//   btn_freeze  raw button: toggle the frozen snapshot
//   mode_auto   level: auto-rotate whenever not frozen
//   led         digit i at [i*7 +: 7], bit0=a .. bit6=g, active-high
//   sel_out     index of the displayed source
//   frozen      high while the snapshot is displayed
module debug_hex_panel #(
  parameter int NUM_DIGITS   = 8,
  parameter int NUM_SRC      = 4,
  parameter int DEB_CYCLES   = 16,
  parameter int ROT_CYCLES   = 50000000,
  parameter int FLASH_CYCLES = 4000000,
  localparam int DATA_W = 4 * NUM_DIGITS,
  localparam int SEL_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic                      btn_next,
  input  logic                      btn_freeze,
  input  logic                      mode_auto,
  output logic [NUM_DIGITS*7-1:0]   led,
  output logic [SEL_W-1:0]          sel_out,
  output logic                      frozen
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam int TMR_W = (ROT_CYCLES > 1) ? $clog2(ROT_CYCLES) : 1;

  if (NUM_DIGITS < 1 || NUM_SRC < 1 || DEB_CYCLES < 1 || ROT_CYCLES < 1 || FLASH_CYCLES < 1) begin : g_param_check
    $error("debug_hex_panel: size and cycle parameters must all be >= 1");
  end

  typedef enum logic [1:0] {
    LIVE   = 2'd0,
    AUTO   = 2'd1,
    FROZEN = 2'd2
  } state_t;

  state_t            state_q;
  logic [SEL_W-1:0]  sel_q;
  logic [TMR_W-1:0]  timer_q;
  logic [TMR_W-1:0]  timer_d;
  logic              frozen_q;
  logic [DATA_W-1:0] snap_q [NUM_SRC];

  // ---------------------------------------------------------------------------
  // Debounce: index 0 = next, index 1 = freeze.
  // ---------------------------------------------------------------------------
  logic [1:0] btn_raw;
  logic [1:0] press;
  assign btn_raw = {btn_freeze, btn_next};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_deb
      logic [DEB_W-1:0] cnt_q;
      logic [DEB_W-1:0] cnt_d;
      logic             lvl_q;
      logic             lvl_d;

      always_comb begin
        if (!btn_raw[gi]) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_W'(DEB_CYCLES)) begin
          cnt_d = cnt_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        lvl_d = (cnt_d == DEB_W'(DEB_CYCLES));
      end

      // The pulse is taken from the level's next value, so the press acts on
      // the same clock the counter reaches DEB_CYCLES. Saturation means a held
      // button never produces another pulse.
      assign press[gi] = lvl_d & ~lvl_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q <= '0;
          lvl_q <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          lvl_q <= lvl_d;
        end
      end
    end
  endgenerate

  logic next_press;
  logic freeze_press;
  assign next_press   = press[0];
  assign freeze_press = press[1];

  // ---------------------------------------------------------------------------
  // Rotate timer.
  // The timer only runs while the panel stays in AUTO.
  // A next press restarts the period. When a next press and the terminal
  // count land on the same clock, sel still advances by exactly one.
  // ---------------------------------------------------------------------------
  logic rot_tick;

  always_comb begin
    timer_d  = '0;
    rot_tick = 1'b0;
    if (state_q == AUTO && mode_auto && !freeze_press && !next_press) begin
      if (timer_q == TMR_W'(ROT_CYCLES - 1)) begin
        rot_tick = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  logic [SEL_W-1:0] sel_inc;
  assign sel_inc = (sel_q == SEL_W'(NUM_SRC - 1)) ? '0 : sel_q + 1'b1;

  // ---------------------------------------------------------------------------
  // Control FSM: state, source select, timer and snapshot.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LIVE;
      sel_q    <= '0;
      timer_q  <= '0;
      frozen_q <= 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
        snap_q[k] <= '0;
      end
    end else begin
      timer_q <= timer_d;
      if (next_press || rot_tick) begin
        sel_q <= sel_inc;
      end
      case (state_q)
        LIVE, AUTO: begin
          if (freeze_press) begin
            state_q  <= FROZEN;
            frozen_q <= 1'b1;
            for (int k = 0; k < NUM_SRC; k++) begin
              snap_q[k] <= src_data[k*DATA_W +: DATA_W];
            end
          end else if (state_q == LIVE && mode_auto) begin
            state_q <= AUTO;
          end else if (state_q == AUTO && !mode_auto) begin
            state_q <= LIVE;
          end
        end
        FROZEN: begin
          if (freeze_press) begin
            state_q  <= mode_auto ? AUTO : LIVE;
            frozen_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= LIVE;
          frozen_q <= 1'b0;
        end
      endcase
    end
  end

  assign sel_out = sel_q;
  assign frozen  = frozen_q;

  // ---------------------------------------------------------------------------
  // Displayed word and hex decode.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] disp_word;

  always_comb begin
    disp_word = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel_q == SEL_W'(k)) begin
        disp_word = (state_q == FROZEN) ? snap_q[k] : src_data[k*DATA_W +: DATA_W];
      end
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'h0: seg7 = 7'h3F;
      4'h1: seg7 = 7'h06;
      4'h2: seg7 = 7'h5B;
      4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;
      4'h5: seg7 = 7'h6D;
      4'h6: seg7 = 7'h7D;
      4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;
      4'h9: seg7 = 7'h6F;
      4'hA: seg7 = 7'h77;
      4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;
      4'hD: seg7 = 7'h5E;
      4'hE: seg7 = 7'h79;
      default: seg7 = 7'h71;
    endcase
  endfunction

  logic [NUM_DIGITS*7-1:0] seg_plain;
  logic [NUM_DIGITS*7-1:0] led_d;
  logic [NUM_DIGITS*7-1:0] led_q;

  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_dec
      assign seg_plain[gi*7 +: 7] = seg7(disp_word[gi*4 +: 4]);
    end
  endgenerate

`ifdef DEBUG_PANEL_CHANGE_FLASH_EN
  localparam int FL_W = $clog2(FLASH_CYCLES + 1);

  // The word currently on led is remembered along with the sel and state
  // that produced it.
  // A digit only counts as changed when sel and state are unchanged, so
  // switching source or mode never causes a flash.
  logic [DATA_W-1:0] shown_word_q;
  logic [SEL_W-1:0]  shown_sel_q;
  state_t            shown_state_q;
  logic              shown_valid_q;
  logic              track;

  assign track = shown_valid_q && (state_q != FROZEN) &&
                 (shown_sel_q == sel_q) && (shown_state_q == state_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      shown_word_q  <= '0;
      shown_sel_q   <= '0;
      shown_state_q <= LIVE;
      shown_valid_q <= 1'b0;
    end else begin
      shown_word_q  <= disp_word;
      shown_sel_q   <= sel_q;
      shown_state_q <= state_q;
      shown_valid_q <= 1'b1;
    end
  end

  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_flash
      logic [FL_W-1:0] flash_q;
      logic [FL_W-1:0] flash_d;

      always_comb begin
        flash_d = '0;
        if (state_q != FROZEN) begin
          if (track && (shown_word_q[gi*4 +: 4] != disp_word[gi*4 +: 4])) begin
            flash_d = FL_W'(FLASH_CYCLES);
          end else if (flash_q != '0) begin
            flash_d = flash_q - 1'b1;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          flash_q <= '0;
        end else begin
          flash_q <= flash_d;
        end
      end

      assign led_d[gi*7 +: 7] = (flash_d != '0) ? 7'h00 : seg_plain[gi*7 +: 7];
    end
  endgenerate
`else
  assign led_d = seg_plain;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q <= '0;
    end else begin
      led_q <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_debug_hex_panel.sv
// tb_debug_hex_panel
//   Directed steps followed by a randomized run. Every clock is compared
//   against a behavioural model of the panel. The model works in terms of
//   run lengths of the raw buttons, a mode number, a source index taken
//   modulo NUM_SRC, and a segment lookup table.
module tb_debug_hex_panel;
  localparam int ND  = 8;
  localparam int NS  = 3;
  localparam int DEB = 4;
  localparam int ROT = 10;
  localparam int FL  = 3;
  localparam int DW  = 4 * ND;

  localparam int M_LIVE   = 0;
  localparam int M_AUTO   = 1;
  localparam int M_FROZEN = 2;

  logic              clk        = 1'b0;
  logic              rst        = 1'b1;
  logic [NS*DW-1:0]  src_data   = '0;
  logic              btn_next   = 1'b0;
  logic              btn_freeze = 1'b0;
  logic              mode_auto  = 1'b0;
  logic [ND*7-1:0]   led;
  logic [1:0]        sel_out;
  logic              frozen;

  int total = 0;
  int bad   = 0;

  debug_hex_panel #(
    .NUM_DIGITS  (ND),
    .NUM_SRC     (NS),
    .DEB_CYCLES  (DEB),
    .ROT_CYCLES  (ROT),
    .FLASH_CYCLES(FL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .src_data  (src_data),
    .btn_next  (btn_next),
    .btn_freeze(btn_freeze),
    .mode_auto (mode_auto),
    .led       (led),
    .sel_out   (sel_out),
    .frozen    (frozen)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model state.
  int          m_run_next;
  int          m_run_frz;
  int          m_mode;
  int          m_sel;
  int          m_timer;
  logic [31:0] m_snap [NS];
  logic [55:0] m_led;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock, using the inputs that were held across
  // the edge.
  task automatic model_clock();
    logic [31:0] w;
    bit pn;
    bit pf;
    bit adv;
    if (rst) begin
      m_led      = '0;
      m_sel      = 0;
      m_mode     = M_LIVE;
      m_timer    = 0;
      m_run_next = 0;
      m_run_frz  = 0;
      for (int k = 0; k < NS; k++) m_snap[k] = '0;
      return;
    end
    w = (m_mode == M_FROZEN) ? m_snap[m_sel] : src_data[m_sel*DW +: DW];
    for (int i = 0; i < ND; i++) m_led[i*7 +: 7] = seg_tab[w[i*4 +: 4]];

    m_run_next = btn_next   ? m_run_next + 1 : 0;
    m_run_frz  = btn_freeze ? m_run_frz + 1  : 0;
    pn  = (m_run_next == DEB);
    pf  = (m_run_frz == DEB);
    adv = pn;

    if (m_mode == M_AUTO && mode_auto && !pf) begin
      if (pn) m_timer = 0;
      else if (m_timer == ROT - 1) begin
        adv = 1;
        m_timer = 0;
      end else m_timer++;
    end else begin
      m_timer = 0;
    end

    if (pf) begin
      if (m_mode == M_FROZEN) m_mode = mode_auto ? M_AUTO : M_LIVE;
      else begin
        for (int k = 0; k < NS; k++) m_snap[k] = src_data[k*DW +: DW];
        m_mode = M_FROZEN;
      end
    end else if (m_mode == M_LIVE && mode_auto) m_mode = M_AUTO;
    else if (m_mode == M_AUTO && !mode_auto) m_mode = M_LIVE;

    if (adv) m_sel = (m_sel + 1) % NS;
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    chk("led", led, m_led);
    chk("sel_out", sel_out, m_sel);
    chk("frozen", frozen, (m_mode == M_FROZEN));
  endtask

  task automatic press_next();
    btn_next = 1'b1;
    repeat (DEB) step();
    btn_next = 1'b0;
    step();
    $display("press next   -> sel_out=%0d frozen=%0d", sel_out, frozen);
  endtask

  task automatic press_freeze();
    btn_freeze = 1'b1;
    repeat (DEB) step();
    btn_freeze = 1'b0;
    step();
    $display("press freeze -> sel_out=%0d frozen=%0d", sel_out, frozen);
  endtask

  initial begin
    // Reset with source 0 loaded.
    src_data[0 +: DW] = 32'h0123ABCD;
    rst = 1'b1;
    repeat (3) step();
    chk("reset_led", led, 0);
    chk("reset_sel", sel_out, 0);
    chk("reset_frozen", frozen, 0);
    rst = 1'b0;
    step();
    chk("digit0_D", led[6:0], 7'h5E);
    chk("digit7_0", led[55:49], 7'h3F);
    chk("sel_after_reset", sel_out, 0);
    $display("reset released -> led=%h", led);

    // A short glitch must not register; a long hold registers exactly once.
    btn_next = 1'b1;
    repeat (3) step();
    btn_next = 1'b0;
    step();
    chk("short_glitch", sel_out, 0);
    btn_next = 1'b1;
    repeat (3) step();
    chk("deb_before_4", sel_out, 0);
    step();
    chk("deb_at_4", sel_out, 1);
    repeat (16) step();
    chk("deb_no_repeat", sel_out, 1);
    btn_next = 1'b0;
    step();
    $display("long hold -> sel_out=%0d", sel_out);

    // Wrap sequence 2, 0, 1.
    press_next();
    chk("wrap_2", sel_out, 2);
    press_next();
    chk("wrap_0", sel_out, 0);
    press_next();
    chk("wrap_1", sel_out, 1);

    // Freeze holds the snapshot while the source changes underneath.
    src_data[DW +: DW] = 32'h11111111;
    step();
    press_freeze();
    chk("frozen_set", frozen, 1);
    src_data[DW +: DW] = 32'h22222222;
    repeat (3) step();
    chk("frozen_hold", led, {8{7'h06}});
    press_freeze();
    chk("frozen_clear", frozen, 0);
    chk("live_again", led, {8{7'h5B}});

    // Auto-rotate: sel advances every ROT clocks after entering AUTO.
    press_next();
    press_next();
    chk("auto_start_sel", sel_out, 0);
    mode_auto = 1'b1;
    repeat (10) step();
    chk("auto_t10", sel_out, 0);
    step();
    chk("auto_t11", sel_out, 1);
    repeat (10) step();
    chk("auto_t21", sel_out, 2);
    repeat (10) step();
    chk("auto_t31", sel_out, 0);
    repeat (4) step();
    // Mid-period next press restarts the rotate count.
    press_next();
    chk("auto_next", sel_out, 1);
    repeat (8) step();
    chk("auto_restart_hold", sel_out, 1);
    step();
    chk("auto_restart_tick", sel_out, 2);
    mode_auto = 1'b0;
    step();

    // Reset while frozen with a partly counted button.
    press_freeze();
    chk("pre_reset_frozen", frozen, 1);
    btn_next = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    step();
    chk("mid_reset_frozen", frozen, 0);
    chk("mid_reset_sel", sel_out, 0);
    btn_next = 1'b0;
    rst = 1'b0;
    repeat (10) step();
    chk("post_reset_sel", sel_out, 0);
    chk("post_reset_frozen", frozen, 0);
    $display("reset in frozen -> sel_out=%0d frozen=%0d", sel_out, frozen);

    // Randomized run against the model.
    for (int c = 0; c < 2000; c++) begin
      int idx;
      if ($urandom_range(5) == 0) btn_next = ~btn_next;
      if ($urandom_range(6) == 0) btn_freeze = ~btn_freeze;
      if ($urandom_range(39) == 0) mode_auto = ~mode_auto;
      if ($urandom_range(3) == 0) begin
        idx = int'($urandom_range(NS - 1));
        src_data[idx*DW +: DW] = $urandom;
      end
      rst = ($urandom_range(299) == 0);
      step();
    end
    $display("random run done -> sel_out=%0d frozen=%0d", sel_out, frozen);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
